btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Execute-stage resolver for branch/jump predictions made at fetch by the BTB.
- Compares the prediction carried down the pipeline against the actual outcome.
- Drives the BTB write port (btb_load, ex_branch_pc, branch_target).
- Issues a fetch redirect plus a multi-cycle flush of wrong-path instructions, and keeps saturating branch/mispredict statistics.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a mispredict (1..7).
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage holds a valid instruction this cycle.
- ex_is_branch  in  1  instruction is a conditional branch, JAL or JALR.
- ex_pc  in  32  PC of the execute-stage instruction.
- ex_actual_taken  in  1  resolved direction (1 for JAL/JALR).
- ex_actual_target  in  32  resolved target address.
- ex_pred_taken  in  1  btb_prediction captured at fetch for this instruction.
- ex_pred_target  in  32  btb_branch_target captured at fetch.
- btb_load  out  1  BTB write enable, one-cycle pulse.
- ex_branch_pc  out  32  PC written as BTB tag.
- branch_target  out  32  target written to the BTB.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch address.
- flush  out  1  squash IF/ID/EX-younger instructions.
- branch_count  out  CNT_WIDTH  resolved branches counted.
- mispredict_count  out  CNT_WIDTH  mispredictions counted.

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM in IDLE, counters 0. Deasserting reset mid-flush returns to IDLE with flush=0 and no pending redirect.
- Resolve event R: ex_valid & ex_is_branch & FSM==IDLE.
- Mispredict M: R & ((pred_taken != actual_taken) | (pred_taken & actual_taken & pred_target != actual_target)).
- Update U: R & actual_taken & (!pred_taken | pred_target != actual_target). The BTB only stores taken entries, so a taken-predicted branch resolving not-taken redirects but does not write.
- All outputs are registered. The event sampled at edge T is visible in the cycle after T (latency 1).
  - btb_load = U; ex_branch_pc = ex_pc; branch_target = ex_actual_target (held when btb_load=0).
  - redirect_valid = M. redirect_pc = actual_taken ? ex_actual_target : ex_pc + 4 (mod 2^32 wrap).
- FSM states:
  - IDLE: on M, go to FLUSH with counter = FLUSH_CYCLES-1 and flush=1.
  - FLUSH: flush=1 while counter decrements. When counter==0 at an edge, go to IDLE (flush=0 next cycle). flush is high for exactly FLUSH_CYCLES cycles, beginning the same cycle as redirect_valid.
  - Any ex_valid in FLUSH is wrong-path: no R, no U, no counting.
- Counters:
  - branch_count += 1 on R. mispredict_count += 1 on M.
  - Both saturate at all-ones and never wrap.
- Non-branch or ex_valid=0 in IDLE: btb_load=0, redirect_valid=0, no count change.
- Correct prediction (taken with matching target, or not-taken/not-taken): count only, no load, no redirect.
- ex_pc or ex_actual_target with bits[1:0]!=0 are passed through unchanged (no alignment check).

Test Plan:
- Reset then ex_valid=1, is_branch=1, pc=0x100, actual taken to 0x200, pred_taken=0 -> next cycle: btb_load=1, ex_branch_pc=0x100, branch_target=0x200, redirect_valid=1, redirect_pc=0x200; flush high 2 cycles; counts 1/1.
- pc=0x100, pred taken to 0x200, actual taken to 0x200 -> no load, no redirect, no flush; branch_count+1, mispredict_count unchanged.
- pc=0x100, pred taken to 0x200, actual not-taken -> redirect_pc=0x104, btb_load=0, flush 2 cycles.
- pc=0x100, pred taken to 0x300, actual taken to 0x200 -> btb_load=1, target 0x200, redirect_pc=0x200.
- A mispredicting branch in each of the 2 flush cycles after a mispredict -> ignored: no load, no redirect, counts +1 only for the first. pc=0xFFFFFFFC not-taken mispredict -> redirect_pc=0x0.
- Force mispredict_count to all-ones (CNT_WIDTH=4, 16 mispredicts) -> holds at 0xF. Assert rst_n low mid-flush -> flush and outputs drop to 0 immediately.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// Execute-stage <-> BTB resolver bus.
//
// Carries the resolved branch coming out of execute, the prediction captured at fetch, and the
// resolver's registered responses: the BTB write port, the fetch redirect and the flush request.
//
//   master : execute pipeline side (drives ex_*, consumes btb/redirect/flush)
//   slave  : btb_update_ctrl
//
//   ex_valid, ex_is_branch   execute holds a valid branch/jump
//   ex_pc                    PC of the execute-stage instruction
//   ex_actual_taken/target   resolved outcome (taken=1 for JAL/JALR)
//   ex_pred_taken/target     BTB prediction made at fetch for this instruction
//   btb_load                 BTB write enable (one-cycle pulse)
//   ex_branch_pc             tag written to the BTB
//   branch_target            target written to the BTB
//   redirect_valid           one-cycle pulse: fetch loads redirect_pc
//   redirect_pc              corrected fetch address
//   flush                    squash younger wrong-path instructions
interface btb_update_ctrl_if;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_actual_taken;
  logic [31:0] ex_actual_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        btb_load;
  logic [31:0] ex_branch_pc;
  logic [31:0] branch_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  modport master (
    output ex_valid, ex_is_branch, ex_pc, ex_actual_taken, ex_actual_target,
           ex_pred_taken, ex_pred_target,
    input  btb_load, ex_branch_pc, branch_target, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_pc, ex_actual_taken, ex_actual_target,
           ex_pred_taken, ex_pred_target,
    output btb_load, ex_branch_pc, branch_target, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// Execute-stage resolver for BTB predictions.
//
// Compares the fetch-time BTB prediction carried down the pipe with the resolved outcome,
// writes taken branches whose target the BTB did not supply correctly, redirects fetch on any
// mispredict and then holds flush for FLUSH_CYCLES cycles while wrong-path instructions drain.
// Saturating counters track resolved branches and mispredictions.
//
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   bus (slave)        execute inputs, BTB write port, redirect and flush outputs
//   branch_count       resolved branches (saturating)
//   mispredict_count   mispredicted branches (saturating)
//
// All outputs are registered: an event sampled at edge T appears in the cycle after T.
module btb_update_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,  // 1..7
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  btb_update_ctrl_if.slave     bus,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned FlushCntW = 3;
  localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax    = {CNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } state_e;

  state_e               state_q, state_d;
  logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
  logic                 flush_q, flush_d;

  logic                 btb_load_q, btb_load_d;
  logic [31:0]          ex_branch_pc_q, ex_branch_pc_d;
  logic [31:0]          branch_target_q, branch_target_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;

  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  // ---------------------------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------------------------
  logic resolve;
  logic target_miss;
  logic mispredict;
  logic update;
  logic [31:0] fallthrough_pc;

  // Anything arriving while flushing is on the wrong path and must not resolve.
  assign resolve     = bus.ex_valid & bus.ex_is_branch & (state_q == StIdle);
  assign target_miss = (bus.ex_pred_target != bus.ex_actual_target);

  assign mispredict  = resolve &
                       ((bus.ex_pred_taken != bus.ex_actual_taken) |
                        (bus.ex_pred_taken & bus.ex_actual_taken & target_miss));

  // The BTB holds only taken entries: a predicted-taken branch that falls through redirects
  // but leaves the stale entry alone.
  assign update      = resolve & bus.ex_actual_taken & (~bus.ex_pred_taken | target_miss);

  assign fallthrough_pc = bus.ex_pc + 32'd4;  // wraps mod 2^32

  // ---------------------------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mispredict) begin
          state_d     = StFlush;
          flush_cnt_d = FlushLoad;
          flush_d     = 1'b1;
        end
      end
      StFlush: begin
        if (flush_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          flush_d     = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        flush_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // BTB write port, redirect and statistics next-state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    btb_load_d         = update;
    ex_branch_pc_d     = ex_branch_pc_q;
    branch_target_d    = branch_target_q;
    redirect_valid_d   = mispredict;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    // Write data is held between loads so the BTB port stays quiet when idle.
    if (update) begin
      ex_branch_pc_d  = bus.ex_pc;
      branch_target_d = bus.ex_actual_target;
    end

    if (mispredict) begin
      redirect_pc_d = bus.ex_actual_taken ? bus.ex_actual_target : fallthrough_pc;
    end

    if (resolve && (branch_count_q != CntMax)) begin
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
    end

    if (mispredict && (mispredict_count_q != CntMax)) begin
      mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      flush_cnt_q        <= '0;
      flush_q            <= 1'b0;
      btb_load_q         <= 1'b0;
      ex_branch_pc_q     <= '0;
      branch_target_q    <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      flush_q            <= flush_d;
      btb_load_q         <= btb_load_d;
      ex_branch_pc_q     <= ex_branch_pc_d;
      branch_target_q    <= branch_target_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign bus.btb_load       = btb_load_q;
  assign bus.ex_branch_pc   = ex_branch_pc_q;
  assign bus.branch_target  = branch_target_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;

  assign branch_count       = branch_count_q;
  assign mispredict_count   = mispredict_count_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: a per-cycle vector table on a 32-bit-counter instance
// with FLUSH_CYCLES=2, plus hand sequences for counter saturation (4-bit counters,
// FLUSH_CYCLES=3) and asynchronous reset in the middle of a flush.
module tb_btb_update_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  btb_update_ctrl_if bus ();
  btb_update_ctrl_if bus2 ();

  logic [31:0] branch_count, mispredict_count;
  logic [3:0]  branch_count2, mispredict_count2;

  btb_update_ctrl #(
    .FLUSH_CYCLES(2),
    .CNT_WIDTH   (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count)
  );

  btb_update_ctrl #(
    .FLUSH_CYCLES(3),
    .CNT_WIDTH   (4)
  ) dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus2),
    .branch_count    (branch_count2),
    .mispredict_count(mispredict_count2)
  );

  typedef struct {
    logic        v;
    logic        b;
    logic [31:0] pc;
    logic        at;
    logic [31:0] atg;
    logic        pt;
    logic [31:0] ptg;
    logic        e_load;
    logic [31:0] e_bpc;
    logic [31:0] e_btgt;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic        e_fl;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic v, logic b, logic [31:0] pc, logic at, logic [31:0] atg,
                              logic pt, logic [31:0] ptg, logic e_load, logic [31:0] e_bpc,
                              logic [31:0] e_btgt, logic e_rv, logic [31:0] e_rpc, logic e_fl,
                              logic [31:0] e_bc, logic [31:0] e_mc);
    vec_t r;
    r.v = v;   r.b = b;     r.pc = pc;       r.at = at;       r.atg = atg;
    r.pt = pt; r.ptg = ptg; r.e_load = e_load; r.e_bpc = e_bpc; r.e_btgt = e_btgt;
    r.e_rv = e_rv; r.e_rpc = e_rpc; r.e_fl = e_fl; r.e_bc = e_bc; r.e_mc = e_mc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic b, input logic [31:0] pc, input logic at,
                        input logic [31:0] atg, input logic pt, input logic [31:0] ptg);
    bus.ex_valid = v;         bus.ex_is_branch = b;      bus.ex_pc = pc;
    bus.ex_actual_taken = at; bus.ex_actual_target = atg;
    bus.ex_pred_taken = pt;   bus.ex_pred_target = ptg;
  endtask

  task automatic drive2(input logic v, input logic b, input logic [31:0] pc, input logic at,
                        input logic [31:0] atg, input logic pt, input logic [31:0] ptg);
    bus2.ex_valid = v;         bus2.ex_is_branch = b;      bus2.ex_pc = pc;
    bus2.ex_actual_taken = at; bus2.ex_actual_target = atg;
    bus2.ex_pred_taken = pt;   bus2.ex_pred_target = ptg;
  endtask

  initial begin
    int fl_cycles;

    //            v  b  pc            at atg           pt ptg     | load bpc     btgt    rv rpc    fl bc mc
    vecs.push_back(mk(1, 1, 32'h100,      1, 32'h200, 0, 32'h0,   1, 32'h100, 32'h200, 1, 32'h200, 1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h200, 1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h200, 0, 1, 1));
    // correct taken prediction
    vecs.push_back(mk(1, 1, 32'h100,      1, 32'h200, 1, 32'h200, 0, 32'h100, 32'h200, 0, 32'h200, 0, 2, 1));
    // predicted taken, actually falls through
    vecs.push_back(mk(1, 1, 32'h100,      0, 32'h200, 1, 32'h200, 0, 32'h100, 32'h200, 1, 32'h104, 1, 3, 2));
    // mispredicting branches during both flush cycles are ignored
    vecs.push_back(mk(1, 1, 32'h500,      1, 32'h600, 0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h104, 1, 3, 2));
    vecs.push_back(mk(1, 1, 32'h700,      1, 32'h800, 0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h104, 0, 3, 2));
    // wrong target
    vecs.push_back(mk(1, 1, 32'h100,      1, 32'h200, 1, 32'h300, 1, 32'h100, 32'h200, 1, 32'h200, 1, 4, 3));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h200, 1, 4, 3));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h200, 0, 4, 3));
    // valid non-branch
    vecs.push_back(mk(1, 0, 32'h900,      1, 32'hA00, 0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h200, 0, 4, 3));
    // fall-through address wraps to zero
    vecs.push_back(mk(1, 1, 32'hFFFFFFFC, 0, 32'h10,  1, 32'h10,  0, 32'h100, 32'h200, 1, 32'h0,   1, 5, 4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h0,   1, 5, 4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h0,   0, 5, 4));
    // correct not-taken prediction
    vecs.push_back(mk(1, 1, 32'h40,       0, 32'h80,  0, 32'h0,   0, 32'h100, 32'h200, 0, 32'h0,   0, 6, 4));
    // misaligned addresses pass straight through
    vecs.push_back(mk(1, 1, 32'h123,      1, 32'h456, 0, 32'h0,   1, 32'h123, 32'h456, 1, 32'h456, 1, 7, 5));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h123, 32'h456, 0, 32'h456, 1, 7, 5));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 32'h123, 32'h456, 0, 32'h456, 0, 7, 5));
    // ex_valid low masks a would-be mispredict
    vecs.push_back(mk(0, 1, 32'h800,      1, 32'h900, 0, 32'h0,   0, 32'h123, 32'h456, 0, 32'h456, 0, 7, 5));

    drive1(0, 0, '0, 0, '0, 0, '0);
    drive2(0, 0, '0, 0, '0, 0, '0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset.btb_load", {31'b0, bus.btb_load}, 32'h0);
    check("reset.ex_branch_pc", bus.ex_branch_pc, 32'h0);
    check("reset.branch_target", bus.branch_target, 32'h0);
    check("reset.redirect_valid", {31'b0, bus.redirect_valid}, 32'h0);
    check("reset.redirect_pc", bus.redirect_pc, 32'h0);
    check("reset.flush", {31'b0, bus.flush}, 32'h0);
    check("reset.branch_count", branch_count, 32'h0);
    check("reset.mispredict_count", mispredict_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive1(vecs[i].v, vecs[i].b, vecs[i].pc, vecs[i].at, vecs[i].atg, vecs[i].pt, vecs[i].ptg);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.btb_load", i), {31'b0, bus.btb_load}, {31'b0, vecs[i].e_load});
      check($sformatf("v%0d.ex_branch_pc", i), bus.ex_branch_pc, vecs[i].e_bpc);
      check($sformatf("v%0d.branch_target", i), bus.branch_target, vecs[i].e_btgt);
      check($sformatf("v%0d.redirect_valid", i), {31'b0, bus.redirect_valid},
            {31'b0, vecs[i].e_rv});
      check($sformatf("v%0d.redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
      check($sformatf("v%0d.flush", i), {31'b0, bus.flush}, {31'b0, vecs[i].e_fl});
      check($sformatf("v%0d.branch_count", i), branch_count, vecs[i].e_bc);
      check($sformatf("v%0d.mispredict_count", i), mispredict_count, vecs[i].e_mc);
    end
    @(negedge clk);
    drive1(0, 0, '0, 0, '0, 0, '0);

    // Saturation on the 4-bit instance; also measures its 3-cycle flush.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive2(1, 1, 32'h1000, 1, 32'h2000, 0, 32'h0);
      @(posedge clk);
      #1;
      fl_cycles = int'(bus2.flush);
      @(negedge clk);
      drive2(0, 0, '0, 0, '0, 0, '0);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        fl_cycles += int'(bus2.flush);
      end
      if (i == 0) check("sat.flush_len3", fl_cycles, 32'd3);
      if (i == 14) check("sat.mispredict_15", {28'b0, mispredict_count2}, 32'hF);
    end
    check("sat.mispredict_hold", {28'b0, mispredict_count2}, 32'hF);
    check("sat.branch_hold", {28'b0, branch_count2}, 32'hF);

    // Asynchronous reset in the middle of a flush.
    @(negedge clk);
    drive1(1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    @(posedge clk);
    #1;
    check("rstmid.flush_before", {31'b0, bus.flush}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.flush", {31'b0, bus.flush}, 32'h0);
    check("rstmid.redirect_valid", {31'b0, bus.redirect_valid}, 32'h0);
    check("rstmid.btb_load", {31'b0, bus.btb_load}, 32'h0);
    check("rstmid.redirect_pc", bus.redirect_pc, 32'h0);
    check("rstmid.branch_count", branch_count, 32'h0);
    check("rstmid.mispredict_count", mispredict_count, 32'h0);
    @(negedge clk);
    drive1(0, 0, '0, 0, '0, 0, '0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rstmid.after%0d.flush", k), {31'b0, bus.flush}, 32'h0);
      check($sformatf("rstmid.after%0d.redirect", k), {31'b0, bus.redirect_valid}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
